id_sequence_checker: RTL and testbench

Receive-side counterpart to the ID sequence generator FSM. Samples a 4-bit digit stream under a valid strobe and tracks progress through the fixed 8-digit ID sequence 0,1,2,4,2,8,6,5. Pulses `match` when the complete sequence arrives in order and pulses `error` on any out-of-order digit. Keeps a saturating count of completed matches; it sits on the output side of the generator for self-check and loopback testing.

---
 rtl/id_seq_pkg.sv | 51 +++++
 rtl/sat_counter.sv | 32 +++
 rtl/id_sequence_checker.sv | 83 ++++++++
 tb/tb_id_sequence_checker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/id_seq_pkg.sv
// Shared definitions for the ID sequence generator and checker.
// Both ends import this package so they agree on the digit order and
// on the state encoding, which is the sequence position itself.
package id_seq_pkg;

  // Number of digits in the ID sequence.
  localparam int SEQ_LEN = 8;

  // Width of a single digit and of the position/state register.
  localparam int DIGIT_W = 4;
  localparam int POS_W   = 4;

  // The fixed ID sequence, indexed by position.
  localparam logic [DIGIT_W-1:0] ID_SEQ [0:SEQ_LEN-1] = '{
    4'd0, 4'd1, 4'd2, 4'd4, 4'd2, 4'd8, 4'd6, 4'd5
  };

  // State encodings; the encoding equals the number of digits matched.
  localparam logic [POS_W-1:0] P0 = 4'd0;
  localparam logic [POS_W-1:0] P1 = 4'd1;
  localparam logic [POS_W-1:0] P2 = 4'd2;
  localparam logic [POS_W-1:0] P3 = 4'd3;
  localparam logic [POS_W-1:0] P4 = 4'd4;
  localparam logic [POS_W-1:0] P5 = 4'd5;
  localparam logic [POS_W-1:0] P6 = 4'd6;
  localparam logic [POS_W-1:0] P7 = 4'd7;

  // Digit expected while sitting in a given state. Positions beyond the
  // sequence never occur; they map to the first digit for safety.
  function automatic logic [DIGIT_W-1:0] expected_digit(input logic [POS_W-1:0] pos);
    logic [DIGIT_W-1:0] d;
    d = ID_SEQ[0];
    if (pos < POS_W'(SEQ_LEN)) begin
      d = ID_SEQ[pos[2:0]];
    end
    return d;
  endfunction

  // Fallback state after a wrong digit. The first sequence digit (0)
  // appears nowhere else in the sequence, so a wrong digit that equals it
  // is itself a valid start and lands in P1; anything else restarts at P0.
  function automatic logic [POS_W-1:0] fallback_state(input logic [DIGIT_W-1:0] d);
    logic [POS_W-1:0] s;
    s = P0;
    if (d == ID_SEQ[0]) begin
      s = P1;
    end
    return s;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over
// increment; at the all-ones value further increments are ignored.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == MAX_COUNT);
  assign count    = r_count;

  // Count register: async reset, sync clear, increment unless saturated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/id_sequence_checker.sv
// Receive-side ID sequence checker. Tracks progress through the fixed
// digit sequence from id_seq_pkg, pulses match on a complete in-order
// sequence, pulses error on any wrong digit and keeps a saturating count
// of completed sequences. All outputs are registered.
module id_sequence_checker
  import id_seq_pkg::*;
#(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [3:0]             digit_in,
  input  logic                   digit_valid,
  output logic [3:0]             position,
  output logic                   match,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] match_count
);

  logic [POS_W-1:0]   r_state;
  logic               r_match;
  logic               r_error;

  logic [DIGIT_W-1:0] w_expected;
  logic               w_hit;
  logic [POS_W-1:0]   w_state_next;
  logic               w_match_next;
  logic               w_error_next;

  assign w_expected = expected_digit(r_state);
  assign w_hit      = (digit_in == w_expected);

  // Next state and pulse decode; clear dominates, invalid cycles hold.
  always_comb begin
    w_state_next = r_state;
    w_match_next = 1'b0;
    w_error_next = 1'b0;
    if (clear) begin
      w_state_next = P0;
    end else if (digit_valid) begin
      if (w_hit) begin
        if (r_state == P7) begin
          w_state_next = P0;
          w_match_next = 1'b1;
        end else begin
          w_state_next = r_state + 4'd1;
        end
      end else begin
        w_state_next = fallback_state(digit_in);
        w_error_next = 1'b1;
      end
    end
  end

  // State and pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= P0;
      r_match <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_match <= w_match_next;
      r_error <= w_error_next;
    end
  end

  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_match_count (
    .clock (clock),
    .reset (reset),
    .clr   (clear),
    .inc   (w_match_next),
    .count (match_count)
  );

  assign position = r_state;
  assign match    = r_match;
  assign error    = r_error;

endmodule

// File: tb/tb_id_sequence_checker.sv
// Scoreboard bench for id_sequence_checker. The driver applies one input
// vector per cycle and queues the hand-derived response for the following
// cycle; a monitor pops and compares after every rising edge.
module tb_id_sequence_checker;

  logic       clock;
  logic       reset;
  logic       clear;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic [3:0] position;
  logic       match;
  logic       error;
  logic [7:0] match_count;

  typedef struct {
    logic [3:0] pos;
    logic       m;
    logic       e;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [3:0] seq_digits [0:7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd2, 4'd8, 4'd6, 4'd5};
  logic [3:0] seq_pos    [0:7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};

  id_sequence_checker #(.COUNT_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .position    (position),
    .match       (match),
    .error       (error),
    .match_count (match_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One input vector per cycle plus its expected registered response.
  task automatic drive(input logic v, input logic [3:0] d, input logic c,
                       input logic [3:0] ep, input logic em, input logic ee,
                       input logic [7:0] ec);
    exp_t x;
    @(negedge clock);
    digit_valid = v;
    digit_in    = d;
    clear       = c;
    x.pos = ep; x.m = em; x.e = ee; x.cnt = ec;
    exp_q.push_back(x);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #2;
    check({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  // Monitor: compare the queued expectation after each rising edge.
  always @(posedge clock) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("position",    position,    x.pos);
      check("match",       match,       x.m);
      check("error",       error,       x.e);
      check("match_count", match_count, x.cnt);
      check("match_and_error", match & error, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; digit_in = 4'd0; digit_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_position",    position,    0);
    check("reset_match",       match,       0);
    check("reset_error",       error,       0);
    check("reset_match_count", match_count, 0);
    @(negedge clock);
    reset = 1'b0;

    // Clean sequence.
    drive(1, 4'd0, 0, 4'd1, 0, 0, 8'd0);
    drive(1, 4'd1, 0, 4'd2, 0, 0, 8'd0);
    drive(1, 4'd2, 0, 4'd3, 0, 0, 8'd0);
    drive(1, 4'd4, 0, 4'd4, 0, 0, 8'd0);
    drive(1, 4'd2, 0, 4'd5, 0, 0, 8'd0);
    drive(1, 4'd8, 0, 4'd6, 0, 0, 8'd0);
    drive(1, 4'd6, 0, 4'd7, 0, 0, 8'd0);
    drive(1, 4'd5, 0, 4'd0, 1, 0, 8'd1);
    drive(0, 4'd0, 0, 4'd0, 0, 0, 8'd1);
    drive(0, 4'd0, 0, 4'd0, 0, 0, 8'd1);

    // Mismatch then full sequence, then zero fallback.
    drive(0, 4'd9, 1, 4'd0, 0, 0, 8'd0);
    drive(1, 4'd0, 0, 4'd1, 0, 0, 8'd0);
    drive(1, 4'd1, 0, 4'd2, 0, 0, 8'd0);
    drive(1, 4'd2, 0, 4'd3, 0, 0, 8'd0);
    drive(1, 4'd7, 0, 4'd0, 0, 1, 8'd0);
    drive(1, 4'd0, 0, 4'd1, 0, 0, 8'd0);
    drive(1, 4'd1, 0, 4'd2, 0, 0, 8'd0);
    drive(1, 4'd2, 0, 4'd3, 0, 0, 8'd0);
    drive(1, 4'd4, 0, 4'd4, 0, 0, 8'd0);
    drive(1, 4'd2, 0, 4'd5, 0, 0, 8'd0);
    drive(1, 4'd8, 0, 4'd6, 0, 0, 8'd0);
    drive(1, 4'd6, 0, 4'd7, 0, 0, 8'd0);
    drive(1, 4'd5, 0, 4'd0, 1, 0, 8'd1);
    drive(1, 4'd0, 0, 4'd1, 0, 0, 8'd1);
    drive(1, 4'd1, 0, 4'd2, 0, 0, 8'd1);
    drive(1, 4'd0, 0, 4'd1, 0, 1, 8'd1);
    drive(0, 4'd0, 0, 4'd1, 0, 0, 8'd1);
    // Mismatch in P0 with a non-zero digit, and a 9..15 digit mid-sequence.
    drive(0, 4'd9, 1, 4'd0, 0, 0, 8'd0);
    drive(1, 4'd3, 0, 4'd0, 0, 1, 8'd0);
    drive(1, 4'd0, 0, 4'd1, 0, 0, 8'd0);
    drive(1, 4'd1, 0, 4'd2, 0, 0, 8'd0);
    drive(1, 4'd15, 0, 4'd0, 0, 1, 8'd0);
    drive(0, 4'd0, 0, 4'd0, 0, 0, 8'd0);

    // Gapped valid: three invalid cycles with digit 9 between digits.
    for (int i = 0; i < 8; i++) begin
      drive(1, seq_digits[i], 0, seq_pos[i], (i == 7), 0, (i == 7) ? 8'd1 : 8'd0);
      for (int g = 0; g < 3; g++) begin
        drive(0, 4'd9, 0, seq_pos[i], 0, 0, (i == 7) ? 8'd1 : 8'd0);
      end
    end

    // Saturation: 256 back-to-back sequences after a clear.
    drive(0, 4'd9, 1, 4'd0, 0, 0, 8'd0);
    for (int s = 0; s < 256; s++) begin
      for (int i = 0; i < 8; i++) begin
        int done;
        done = (i == 7) ? s + 1 : s;
        if (done > 255) done = 255;
        drive(1, seq_digits[i], 0, seq_pos[i], (i == 7), 0, 8'(done));
      end
    end
    drive(0, 4'd0, 0, 4'd0, 0, 0, 8'd255);

    // Clear with a valid 0 while in P3: clear wins, count drops to 0.
    drive(1, 4'd0, 0, 4'd1, 0, 0, 8'd255);
    drive(1, 4'd1, 0, 4'd2, 0, 0, 8'd255);
    drive(1, 4'd2, 0, 4'd3, 0, 0, 8'd255);
    drive(1, 4'd0, 1, 4'd0, 0, 0, 8'd0);
    drive(0, 4'd0, 0, 4'd0, 0, 0, 8'd0);
    // Clear with the final correct digit in P7: no match, no count.
    for (int i = 0; i < 7; i++) begin
      drive(1, seq_digits[i], 0, seq_pos[i], 0, 0, 8'd0);
    end
    drive(1, 4'd5, 1, 4'd0, 0, 0, 8'd0);
    drive(0, 4'd0, 0, 4'd0, 0, 0, 8'd0);

    // One full match, then advance to P6 for the async reset case.
    for (int i = 0; i < 8; i++) begin
      drive(1, seq_digits[i], 0, seq_pos[i], (i == 7), 0, (i == 7) ? 8'd1 : 8'd0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, seq_digits[i], 0, seq_pos[i], 0, 0, 8'd1);
    end
    drive(0, 4'd0, 0, 4'd6, 0, 0, 8'd1);
    drain("pre_reset");
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_position",    position,    0);
    check("async_reset_match",       match,       0);
    check("async_reset_error",       error,       0);
    check("async_reset_match_count", match_count, 0);
    @(negedge clock);
    reset = 1'b0;
    drive(1, 4'd0, 0, 4'd1, 0, 0, 8'd0);
    drive(0, 4'd0, 0, 4'd1, 0, 0, 8'd0);

    drain("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
